// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the combination-lock sequencer.
//   - FSM state width and encoding (IDLE..SETPW); codes 6 and 7 are unused.
//   - BCD_MAX, the largest legal digit value.
//   - bcd_inc(): one-digit BCD increment with 9 -> 0 wrap.
package lock_pkg;

    localparam int STATE_W = 3;
    localparam int BCD_MAX = 9;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ENTRY   = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK   = 3'd2;
    localparam logic [STATE_W-1:0] ST_OPEN    = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd4;
    localparam logic [STATE_W-1:0] ST_SETPW   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_ENTRY   = ST_ENTRY,
        S_CHECK   = ST_CHECK,
        S_OPEN    = ST_OPEN,
        S_LOCKOUT = ST_LOCKOUT,
        S_SETPW   = ST_SETPW
    } state_t;

    // Any value at or above BCD_MAX wraps to 0, so a digit can never leave 0..9.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'(BCD_MAX)) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/lock_digit_bank.sv
// lock_digit_bank: NUM_DIGITS packed BCD digit registers, digit1 in [3:0].
// Ports:
//   clk, rst   clock and asynchronous active-high reset (value -> RESET_VAL)
//   clear      set all digits to 0 (highest priority)
//   load       load the whole bank from load_val
//   inc        BCD-increment the digit selected by inc_idx (lowest priority)
//   value      current packed contents
module lock_digit_bank
    import lock_pkg::*;
#(
    parameter int                        NUM_DIGITS = 8,
    parameter logic [4*NUM_DIGITS-1:0]   RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         load,
    input  logic [4*NUM_DIGITS-1:0]      load_val,
    input  logic                         inc,
    input  logic [2:0]                   inc_idx,
    output logic [4*NUM_DIGITS-1:0]      value
);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [4*NUM_DIGITS-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_val;
        end else if (inc) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (inc_idx == 3'(i)) begin
                    value_d[4*i +: 4] = bcd_inc(value_q[4*i +: 4]);
                end
            end
        end
    end

    // NOTE: every flop here, including the whole digit array, has an async
    // reset value; the stored password must revert when rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: controller for the NUM_DIGITS-digit combination lock.
// Sequences digit entry, code check, open, lockout and password change.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   btn_next         strobe: advance cursor / submit (highest priority)
//   btn_set          strobe: enter password-change mode (acts only in OPEN)
//   btn_up           strobe: BCD-increment digit at cursor (lowest priority)
//   digits_showing   packed entry digits, digit1 in [3:0]
//   cursor           index of the digit being edited
//   state            current FSM state code
//   unlocked         high while in OPEN
//   alarm            high while in LOCKOUT
//   tries            consecutive failed attempts
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                        NUM_DIGITS     = 8,
    parameter int                        MAX_TRIES      = 3,
    parameter int                        OPEN_CYCLES    = 500,
    parameter int                        LOCKOUT_CYCLES = 1000,
    parameter logic [4*NUM_DIGITS-1:0]   DEFAULT_PW     = 32'h12345678
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_next,
    input  logic                         btn_up,
    input  logic                         btn_set,
    output logic [4*NUM_DIGITS-1:0]      digits_showing,
    output logic [2:0]                   cursor,
    output logic [STATE_W-1:0]           state,
    output logic                         unlocked,
    output logic                         alarm,
    output logic [1:0]                   tries
);

    localparam int TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [2:0]         LAST_CURSOR = 3'(NUM_DIGITS - 1);
    localparam logic [TIMER_W-1:0] OPEN_LOAD   = TIMER_W'(OPEN_CYCLES);
    localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

    state_t               state_q,  state_d;
    logic [2:0]           cursor_q, cursor_d;
    logic [1:0]           tries_q,  tries_d;
    logic [TIMER_W-1:0]   timer_q,  timer_d;

    logic                    entry_clear, entry_load, entry_inc;
    logic                    pw_load;
    logic [4*NUM_DIGITS-1:0] entry_value, pw_value;

    // Only the highest-priority strobe acts in a cycle; the rest are dropped.
    logic do_next, do_set, do_up;
    assign do_next = btn_next;
    assign do_set  = btn_set & ~btn_next;
    assign do_up   = btn_up  & ~btn_next & ~btn_set;

    lock_digit_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .RESET_VAL  ('0)
    ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .clear    (entry_clear),
        .load     (entry_load),
        .load_val (pw_value),
        .inc      (entry_inc),
        .inc_idx  (cursor_q),
        .value    (entry_value)
    );

    lock_digit_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .RESET_VAL  (DEFAULT_PW)
    ) u_password (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .load     (pw_load),
        .load_val (entry_value),
        .inc      (1'b0),
        .inc_idx  (3'd0),
        .value    (pw_value)
    );

    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cursor_d    = cursor_q;
        tries_d     = tries_q;
        timer_d     = timer_q;
        entry_clear = 1'b0;
        entry_load  = 1'b0;
        entry_inc   = 1'b0;
        pw_load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (do_next) begin
                    entry_clear = 1'b1;
                    cursor_d    = 3'd0;
                    state_d     = S_ENTRY;
                end
            end

            S_ENTRY, S_SETPW: begin
                if (do_next) begin
                    if (cursor_q != LAST_CURSOR) begin
                        cursor_d = cursor_q + 3'd1;
                    end else if (state_q == S_ENTRY) begin
                        state_d = S_CHECK;
                    end else begin
                        pw_load = 1'b1;
                        timer_d = OPEN_LOAD;
                        state_d = S_OPEN;
                    end
                end else if (do_up) begin
                    entry_inc = 1'b1;
                end
            end

            S_CHECK: begin
                if (entry_value == pw_value) begin
                    tries_d = 2'd0;
                    timer_d = OPEN_LOAD;
                    state_d = S_OPEN;
                end else if (int'(tries_q) + 1 < MAX_TRIES) begin
                    tries_d     = tries_q + 2'd1;
                    entry_clear = 1'b1;
                    cursor_d    = 3'd0;
                    state_d     = S_ENTRY;
                end else begin
                    tries_d = 2'd0;
                    timer_d = LOCK_LOAD;
                    state_d = S_LOCKOUT;
                end
            end

            S_OPEN: begin
                timer_d = timer_q - TIMER_ONE;
                if (do_next) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (do_set) begin
                    timer_d    = '0;
                    entry_load = 1'b1;
                    cursor_d   = 3'd0;
                    state_d    = S_SETPW;
                end else if (timer_q == TIMER_ONE) begin
                    state_d = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                timer_d = timer_q - TIMER_ONE;
                if (timer_q == TIMER_ONE) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cursor_q <= 3'd0;
            tries_q  <= 2'd0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            tries_q  <= tries_d;
            timer_q  <= timer_d;
        end
    end

    assign digits_showing = entry_value;
    assign cursor         = cursor_q;
    assign state          = state_q;
    assign tries          = tries_q;
    assign unlocked       = (state_q == S_OPEN);
    assign alarm          = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed, table-driven bench for lock_sequencer with
// OPEN_CYCLES=8 and LOCKOUT_CYCLES=16. Codes are packed values; cursor 0
// edits [3:0], so the default password 32'h12345678 is keyed in as 8,7,...,1.
module tb_lock_sequencer;

    localparam int OPEN_C = 8;
    localparam int LOCK_C = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next, btn_up, btn_set;
    logic [31:0] digits_showing;
    logic [2:0]  cursor;
    logic [2:0]  state;
    logic        unlocked, alarm;
    logic [1:0]  tries;

    int n_checks = 0;
    int n_fail   = 0;

    lock_sequencer #(
        .NUM_DIGITS     (8),
        .MAX_TRIES      (3),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C),
        .DEFAULT_PW     (32'h12345678)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_next       (btn_next),
        .btn_up         (btn_up),
        .btn_set        (btn_set),
        .digits_showing (digits_showing),
        .cursor         (cursor),
        .state          (state),
        .unlocked       (unlocked),
        .alarm          (alarm),
        .tries          (tries)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        nxt;
        logic        up;
        logic        set;
        int          reps;
        logic [2:0]  st;
        logic [2:0]  cur;
        logic [31:0] dig;
        logic [1:0]  tr;
        logic        unl;
        logic        alm;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given strobes; returns 1 ns after the edge.
    task automatic pulse(input logic n, input logic u, input logic s);
        @(negedge clk);
        btn_next = n;
        btn_up   = u;
        btn_set  = s;
        @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_up   = 1'b0;
        btn_set  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Keys in a code from cursor 0 with a cleared entry; the last next submits.
    task automatic enter_digits(input logic [31:0] code);
        for (int i = 0; i < 8; i++) begin
            repeat (int'(code[4*i +: 4])) pulse(1'b0, 1'b1, 1'b0);
            pulse(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic open_with(input string name, input logic [31:0] code);
        pulse(1'b1, 1'b0, 1'b0);
        enter_digits(code);
        check({name, " check state"}, 32'(state), 32'd2);
        pulse(1'b0, 1'b0, 1'b0);
        check({name, " open state"}, 32'(state), 32'd3);
        check({name, " unlocked"}, 32'(unlocked), 32'd1);
    endtask

    task automatic run_to_lockout(input string name);
        pulse(1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 3; r++) begin
            repeat (8) pulse(1'b1, 1'b0, 1'b0);
            check($sformatf("%s round%0d check", name, r), 32'(state), 32'd2);
            pulse(1'b0, 1'b0, 1'b0);
            if (r < 3) begin
                check($sformatf("%s round%0d state", name, r), 32'(state), 32'd1);
                check($sformatf("%s round%0d tries", name, r), 32'(tries), 32'(r));
            end
        end
        check({name, " lockout state"}, 32'(state), 32'd4);
        check({name, " alarm"}, 32'(alarm), 32'd1);
        check({name, " tries cleared"}, 32'(tries), 32'd0);
    endtask

    task automatic async_reset_check(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({name, " state"}, 32'(state), 32'd0);
        check({name, " digits"}, digits_showing, 32'h0);
        check({name, " cursor"}, 32'(cursor), 32'd0);
        check({name, " tries"}, 32'(tries), 32'd0);
        check({name, " unlocked"}, 32'(unlocked), 32'd0);
        check({name, " alarm"}, 32'(alarm), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_up   = 1'b0;
        btn_set  = 1'b0;

        // Reset state while rst is held.
        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset digits", digits_showing, 32'h0);
        check("reset cursor", 32'(cursor), 32'd0);
        check("reset tries", 32'(tries), 32'd0);
        check("reset unlocked", 32'(unlocked), 32'd0);
        check("reset alarm", 32'(alarm), 32'd0);
        #10 rst = 1'b0;

        // Table: {next, up, set, repeat count, then expected state after the
        // repeats: state, cursor, digits, tries, unlocked, alarm}.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1, 3'd1, 3'd0, 32'h00000000, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 9, 3'd1, 3'd0, 32'h00000009, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1, 3'd1, 3'd0, 32'h00000000, 2'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 3, 3'd1, 3'd0, 32'h00000003, 2'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1, 3'd1, 3'd1, 32'h00000003, 2'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2, 3'd1, 3'd1, 32'h00000023, 2'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 6, 3'd1, 3'd7, 32'h00000023, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1, 3'd2, 3'd7, 32'h00000023, 2'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1, 3'd1, 3'd0, 32'h00000000, 2'd1, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            repeat (vecs[i].reps) pulse(vecs[i].nxt, vecs[i].up, vecs[i].set);
            check($sformatf("vec%0d state", i),    32'(state),     32'(vecs[i].st));
            check($sformatf("vec%0d cursor", i),   32'(cursor),    32'(vecs[i].cur));
            check($sformatf("vec%0d digits", i),   digits_showing, vecs[i].dig);
            check($sformatf("vec%0d tries", i),    32'(tries),     32'(vecs[i].tr));
            check($sformatf("vec%0d unlocked", i), 32'(unlocked),  32'(vecs[i].unl));
            check($sformatf("vec%0d alarm", i),    32'(alarm),     32'(vecs[i].alm));
        end

        // Correct code: CHECK for one cycle, OPEN for exactly OPEN_C clocks.
        apply_reset();
        pulse(1'b1, 1'b0, 1'b0);
        enter_digits(32'h12345678);
        check("good check state", 32'(state), 32'd2);
        check("good check unlocked", 32'(unlocked), 32'd0);
        pulse(1'b0, 1'b0, 1'b0);
        check("good open state", 32'(state), 32'd3);
        check("good open tries", 32'(tries), 32'd0);
        for (int k = 2; k <= OPEN_C; k++) begin
            pulse(1'b0, 1'b1, 1'b0);
            check($sformatf("good open cycle%0d", k), 32'(unlocked), 32'd1);
        end
        pulse(1'b0, 1'b0, 1'b0);
        check("good timeout state", 32'(state), 32'd0);
        check("good timeout unlocked", 32'(unlocked), 32'd0);

        // Lockout: buttons are ignored for LOCK_C clocks.
        apply_reset();
        run_to_lockout("lock");
        for (int k = 2; k <= LOCK_C; k++) begin
            pulse(1'b1, 1'b1, 1'b1);
            check($sformatf("lock cycle%0d state", k), 32'(state), 32'd4);
        end
        pulse(1'b1, 1'b0, 1'b0);
        check("lock exit state", 32'(state), 32'd0);
        check("lock exit alarm", 32'(alarm), 32'd0);
        check("lock exit tries", 32'(tries), 32'd0);

        // Password change: digit at cursor 7 goes 1 -> 9.
        apply_reset();
        open_with("pwc open", 32'h12345678);
        pulse(1'b0, 1'b0, 1'b1);
        check("pwc setpw state", 32'(state), 32'd5);
        check("pwc setpw cursor", 32'(cursor), 32'd0);
        check("pwc setpw digits", digits_showing, 32'h12345678);
        repeat (7) pulse(1'b1, 1'b0, 1'b0);
        check("pwc cursor7", 32'(cursor), 32'd7);
        repeat (8) pulse(1'b0, 1'b1, 1'b0);
        check("pwc edited digits", digits_showing, 32'h92345678);
        pulse(1'b1, 1'b0, 1'b0);
        check("pwc reopen state", 32'(state), 32'd3);
        repeat (OPEN_C) pulse(1'b0, 1'b0, 1'b0);
        check("pwc timeout state", 32'(state), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        enter_digits(32'h12345678);
        pulse(1'b0, 1'b0, 1'b0);
        check("pwc old code state", 32'(state), 32'd1);
        check("pwc old code tries", 32'(tries), 32'd1);
        enter_digits(32'h92345678);
        pulse(1'b0, 1'b0, 1'b0);
        check("pwc new code state", 32'(state), 32'd3);
        check("pwc new code tries", 32'(tries), 32'd0);

        // next beats set in OPEN.
        pulse(1'b1, 1'b0, 1'b1);
        check("prio open next+set state", 32'(state), 32'd0);

        // Async reset mid-SETPW reverts the changed password.
        open_with("ar1 open", 32'h92345678);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        check("ar1 in setpw", 32'(state), 32'd5);
        async_reset_check("ar1");
        open_with("ar1 default pw", 32'h12345678);

        // Async reset mid-LOCKOUT.
        apply_reset();
        run_to_lockout("ar2");
        repeat (3) pulse(1'b0, 1'b0, 1'b0);
        async_reset_check("ar2");
        open_with("ar2 default pw", 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
